free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter N_PHYS, default N_PHYS_REGS, total physical tags.
REQ-002 SHALL have parameter N_ARCH, default N_ARCH_REGS, architectural registers (tags 0..N_ARCH-1 are mapped at reset).
REQ-003 SHALL have parameter TAG_W, default PREG_W, tag width.
REQ-004 SHALL derive the local constant DEPTH = N_PHYS - N_ARCH as the queue capacity; nothing else may set it.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port alloc_req_i, input, 1, rename requests one destination tag this cycle.
REQ-008 SHALL have port alloc_gnt_o, output, 1, the request is accepted this cycle.
REQ-009 SHALL have port alloc_tag_o, output, TAG_W, the tag at the queue head; meaningful only when alloc_gnt_o=1.
REQ-010 SHALL have port prf_inv_valid_o, output, 1, equal to alloc_req_i & alloc_gnt_o; drives the PRF invalidate port.
REQ-011 SHALL have port prf_inv_tag_o, output, TAG_W, equal to alloc_tag_o.
REQ-012 SHALL have port free_valid_i, input, 1, commit returns one tag this cycle.
REQ-013 SHALL have port free_tag_i, input, TAG_W, the tag being returned.
REQ-014 SHALL have port ckpt_save_i, input, 1, snapshot the head pointer, for example at branch rename.
REQ-015 SHALL have port ckpt_restore_i, input, 1, roll the head pointer back to the snapshot on mispredict.
REQ-016 SHALL have port count_o, output, $clog2(DEPTH+1), the number of free tags.
REQ-017 SHALL have port empty_o, output, 1, asserted when count_o == 0.
REQ-018 SHALL have port overflow_o, output, 1, sticky error flag.

Function
REQ-019 SHALL implement a circular FIFO of DEPTH tag entries with head and tail indices in the range 0..DEPTH-1; each index wraps from DEPTH-1 to 0, and DEPTH need not be a power of two.
REQ-020 SHALL drive alloc_gnt_o = ~empty_o & ~ckpt_restore_i, combinationally, with zero latency.
REQ-021 SHALL, on alloc_req_i & alloc_gnt_o, advance head by one and decrement count.
REQ-022 SHALL, on free_valid_i with free_tag_i != 0, write mem[tail] and advance tail by one; a tag value of 0 is ignored.
REQ-023 SHALL NOT bypass a freed tag to alloc_tag_o in the same cycle; when empty, a simultaneous free and alloc leaves alloc_gnt_o=0 and count becomes 1.
REQ-024 SHALL leave count unchanged on a simultaneous grant and free when not empty.
REQ-025 SHALL ignore a free that arrives while count == DEPTH, and set overflow_o.
REQ-026 SHALL, on ckpt_save_i, store the post-update head into the snapshot register and clear the allocs-since-checkpoint counter; an allocation in the same cycle is excluded from the counter.
REQ-027 SHALL increment the allocs-since-checkpoint counter on every grant after a save.
REQ-028 SHALL, on ckpt_restore_i, set head to the snapshot, set count to count plus the counter plus any same-cycle free, and clear the counter; tail is unaffected.
REQ-029 SHALL give ckpt_restore_i priority over ckpt_save_i in the same cycle.
REQ-030 SHALL keep a restore with no prior save legal, restoring head to its reset value of 0.
REQ-031 SHALL produce no X on any output after reset.

Reset
REQ-032 SHALL, on rst_n low, asynchronously set mem[i] = N_ARCH+i for i = 0..DEPTH-1, head = 0, tail = 0, count = DEPTH, snapshot = 0, counter = 0, and overflow_o = 0.
REQ-033 SHALL, after rst_n is released, drive alloc_tag_o = N_ARCH, alloc_gnt_o = 1, and empty_o = 0.
REQ-034 SHALL, on reset mid-operation, abandon all in-flight state with no recovery.

Structure
REQ-035 SHALL take N_PHYS_REGS, N_ARCH_REGS and PREG_W from the shared ooop_defs package; a preg_t tag typedef SHALL live there.
REQ-036 SHALL be a single module with no sub-modules; the pointer-increment-with-wrap logic SHALL be a local function.

Verification (N_PHYS=64, N_ARCH=32, DEPTH=32)
REQ-037 SHALL verify reset and drain: hold alloc_req_i for 33 cycles -> tags 32..63 granted in order, then alloc_gnt_o=0, empty_o=1, and prf_inv_valid_o pulses 32 times.
REQ-038 SHALL verify the empty case: while empty, free tag 5 and request an alloc in the same cycle -> no grant that cycle; next cycle alloc_tag_o=5 and count_o=1.
REQ-039 SHALL verify checkpoint recovery: save at tag 32, allocate 32..35, then restore -> alloc_tag_o=32 and count_o=32.
REQ-040 SHALL verify restore with a free: after three allocations past a checkpoint, restore and free tag 7 in the same cycle -> count_o=32 and tag 7 is placed at tail.
REQ-041 SHALL verify overflow: free tag 9 while count=32 -> overflow_o=1 and stays 1, and count_o stays 32.
REQ-042 SHALL verify tag 0 and wrap-around: free tag 0 -> no change; then cycle through 40 alloc/free pairs -> pointers wrap with tags in FIFO order.

Source files
------------

// File: rtl/ooop_defs.sv
// Shared out-of-order pipeline definitions: register-file sizing and the physical tag type.
// No logic; constants and typedefs only.
// Imported by rename-stage blocks such as free_list.
package ooop_defs;

  localparam int N_PHYS_REGS = 64;
  localparam int N_ARCH_REGS = 32;
  localparam int PREG_W      = $clog2(N_PHYS_REGS);

  typedef logic [PREG_W-1:0] preg_t;

endpackage

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free tags with one branch checkpoint of the head.
// Latency: grant and head tag are combinational (zero cycles); a freed tag is allocatable next cycle.
// Backpressure: alloc_gnt_o drops when the list is empty or a restore is in progress; frees into a full list are dropped and flagged.
module free_list
  import ooop_defs::*;
#(
  parameter int N_PHYS = N_PHYS_REGS,
  parameter int N_ARCH = N_ARCH_REGS,
  parameter int TAG_W  = PREG_W
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 alloc_req_i,
  output logic                                 alloc_gnt_o,
  output logic [TAG_W-1:0]                     alloc_tag_o,
  output logic                                 prf_inv_valid_o,
  output logic [TAG_W-1:0]                     prf_inv_tag_o,
  input  logic                                 free_valid_i,
  input  logic [TAG_W-1:0]                     free_tag_i,
  input  logic                                 ckpt_save_i,
  input  logic                                 ckpt_restore_i,
  output logic [$clog2(N_PHYS-N_ARCH+1)-1:0]   count_o,
  output logic                                 empty_o,
  output logic                                 overflow_o
);

  localparam int DEPTH = N_PHYS - N_ARCH;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [TAG_W-1:0] tag_t;

  // Pointer advance with explicit wrap so DEPTH need not be a power of two.
  function automatic idx_t ptr_inc(input idx_t p);
    return (p == idx_t'(DEPTH - 1)) ? '0 : p + idx_t'(1);
  endfunction

  tag_t mem_q [DEPTH];
  tag_t mem_d [DEPTH];
  idx_t head_q, head_d;
  idx_t tail_q, tail_d;
  idx_t snap_q, snap_d;
  cnt_t count_q, count_d;
  cnt_t since_q, since_d;
  logic overflow_q, overflow_d;

  logic empty;
  logic full;
  logic gnt;
  logic fire;
  logic free_nz;
  logic free_ok;

  // Handshake decode: grant, accepted alloc, and whether a returned tag is accepted.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == cnt_t'(DEPTH));
    gnt     = ~empty & ~ckpt_restore_i;
    fire    = alloc_req_i & gnt;
    free_nz = free_valid_i & (free_tag_i != '0);
    free_ok = free_nz & ~full;
  end

  // Next-state: queue pointers, occupancy, checkpoint and sticky overflow.
  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    snap_d     = snap_q;
    count_d    = count_q;
    since_d    = since_q;
    overflow_d = overflow_q | (free_nz & full);

    // Freed tags always land at the tail; they are never bypassed to the head this cycle.
    if (free_ok) begin
      mem_d[tail_q] = free_tag_i;
      tail_d        = ptr_inc(tail_q);
    end

    if (ckpt_restore_i) begin
      // Rewind head; tags handed out since the checkpoint become free again.
      head_d  = snap_q;
      count_d = count_q + since_q + cnt_t'(free_ok);
      since_d = '0;
    end else begin
      if (fire) begin
        head_d = ptr_inc(head_q);
      end
      count_d = count_q - cnt_t'(fire) + cnt_t'(free_ok);
      if (ckpt_save_i) begin
        // Snapshot the post-update head, so a same-cycle alloc is not rolled back.
        snap_d  = head_d;
        since_d = '0;
      end else begin
        since_d = since_q + cnt_t'(fire);
      end
    end
  end

  // State registers; reset maps tags N_ARCH..N_PHYS-1 into the queue in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= tag_t'(N_ARCH + i);
      end
      head_q     <= '0;
      tail_q     <= '0;
      snap_q     <= '0;
      count_q    <= cnt_t'(DEPTH);
      since_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      snap_q     <= snap_d;
      count_q    <= count_d;
      since_q    <= since_d;
      overflow_q <= overflow_d;
    end
  end

  assign alloc_gnt_o     = gnt;
  assign alloc_tag_o     = mem_q[head_q];
  assign prf_inv_valid_o = fire;
  assign prf_inv_tag_o   = mem_q[head_q];
  assign count_o         = count_q;
  assign empty_o         = empty;
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: stimulus pushes expected grant tags, a monitor pops on each PRF invalidate.
// Latency: expects grants combinationally in the request cycle.
// Backpressure: checks grant suppression on empty and during restore.
module tb_free_list;

  localparam int TW = 6;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alloc_req_i;
  logic          alloc_gnt_o;
  logic [TW-1:0] alloc_tag_o;
  logic          prf_inv_valid_o;
  logic [TW-1:0] prf_inv_tag_o;
  logic          free_valid_i;
  logic [TW-1:0] free_tag_i;
  logic          ckpt_save_i;
  logic          ckpt_restore_i;
  logic [CW-1:0] count_o;
  logic          empty_o;
  logic          overflow_o;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  logic [TW-1:0] exp_q [$];

  always #5 clk = ~clk;

  free_list #(.N_PHYS(64), .N_ARCH(32), .TAG_W(TW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alloc_req_i     (alloc_req_i),
    .alloc_gnt_o     (alloc_gnt_o),
    .alloc_tag_o     (alloc_tag_o),
    .prf_inv_valid_o (prf_inv_valid_o),
    .prf_inv_tag_o   (prf_inv_tag_o),
    .free_valid_i    (free_valid_i),
    .free_tag_i      (free_tag_i),
    .ckpt_save_i     (ckpt_save_i),
    .ckpt_restore_i  (ckpt_restore_i),
    .count_o         (count_o),
    .empty_o         (empty_o),
    .overflow_o      (overflow_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req_i    = 1'b0;
    free_valid_i   = 1'b0;
    free_tag_i     = '0;
    ckpt_save_i    = 1'b0;
    ckpt_restore_i = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_count", 32'(count_o), 32);
    chk("rst_overflow", 32'(overflow_o), 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_tag", 32'(alloc_tag_o), 32);
    chk("rst_gnt", 32'(alloc_gnt_o), 1);
    chk("rst_empty", 32'(empty_o), 0);
  endtask

  // Monitor: every PRF invalidate pulse is one grant, compared in order against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && prf_inv_valid_o === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL grant_unexpected: got tag %0d expected no grant", alloc_tag_o);
      end else begin
        logic [TW-1:0] e;
        e = exp_q.pop_front();
        chk("grant_tag", 32'(alloc_tag_o), 32'(e));
        chk("inv_tag", 32'(prf_inv_tag_o), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    idle();
    do_reset();

    // Drain: 33 request cycles, tags 32..63 in order, then no grant.
    for (int t = 32; t < 64; t++) exp_q.push_back(TW'(t));
    pulses = 0;
    alloc_req_i = 1'b1;
    repeat (32) step();
    chk("drain_gnt", 32'(alloc_gnt_o), 0);
    chk("drain_empty", 32'(empty_o), 1);
    chk("drain_inv", 32'(prf_inv_valid_o), 0);
    step();
    chk("drain_pulses", 32'(pulses), 32);

    // Empty: free and alloc together produce no grant; freed tag appears next cycle.
    free_valid_i = 1'b1;
    free_tag_i   = 6'd5;
    #1;
    chk("empty_nobypass_gnt", 32'(alloc_gnt_o), 0);
    step();
    idle();
    #1;
    chk("empty_free_tag", 32'(alloc_tag_o), 5);
    chk("empty_free_count", 32'(count_o), 1);
    chk("empty_free_gnt", 32'(alloc_gnt_o), 1);

    // Checkpoint recovery after a mid-operation reset.
    do_reset();
    ckpt_save_i = 1'b1;
    step();
    idle();
    alloc_req_i = 1'b1;
    for (int t = 32; t < 36; t++) exp_q.push_back(TW'(t));
    repeat (4) step();
    chk("pre_restore_count", 32'(count_o), 28);
    ckpt_restore_i = 1'b1;
    #1;
    chk("restore_gnt", 32'(alloc_gnt_o), 0);
    chk("restore_inv", 32'(prf_inv_valid_o), 0);
    step();
    idle();
    #1;
    chk("restore_tag", 32'(alloc_tag_o), 32);
    chk("restore_count", 32'(count_o), 32);

    // Restore with a same-cycle free: one alloc kept, three rolled back, tag 7 lands at tail.
    alloc_req_i = 1'b1;
    exp_q.push_back(6'd32);
    step();
    idle();
    ckpt_save_i = 1'b1;
    step();
    idle();
    alloc_req_i = 1'b1;
    for (int t = 33; t < 36; t++) exp_q.push_back(TW'(t));
    repeat (3) step();
    idle();
    ckpt_restore_i = 1'b1;
    free_valid_i   = 1'b1;
    free_tag_i     = 6'd7;
    step();
    idle();
    #1;
    chk("restore_free_count", 32'(count_o), 32);
    chk("restore_free_tag", 32'(alloc_tag_o), 33);
    for (int t = 33; t < 64; t++) exp_q.push_back(TW'(t));
    exp_q.push_back(6'd7);
    alloc_req_i = 1'b1;
    repeat (32) step();
    idle();
    #1;
    chk("restore_free_drained", 32'(empty_o), 1);

    // Tag 0 is ignored entirely, even when full.
    do_reset();
    free_valid_i = 1'b1;
    free_tag_i   = 6'd0;
    step();
    idle();
    #1;
    chk("tag0_count", 32'(count_o), 32);
    chk("tag0_overflow", 32'(overflow_o), 0);
    chk("tag0_head", 32'(alloc_tag_o), 32);

    // Overflow: free into a full list is dropped and the flag sticks.
    free_valid_i = 1'b1;
    free_tag_i   = 6'd9;
    step();
    idle();
    #1;
    chk("ovf_flag", 32'(overflow_o), 1);
    chk("ovf_count", 32'(count_o), 32);
    chk("ovf_head", 32'(alloc_tag_o), 32);
    repeat (3) step();
    chk("ovf_sticky", 32'(overflow_o), 1);

    // Wrap: one lone alloc, then 40 alloc/free pairs with freed tags 1..40.
    alloc_req_i = 1'b1;
    exp_q.push_back(6'd32);
    step();
    for (int k = 0; k < 40; k++) begin
      if (k < 31) exp_q.push_back(TW'(33 + k));
      else        exp_q.push_back(TW'(1 + (k - 31)));
      alloc_req_i  = 1'b1;
      free_valid_i = 1'b1;
      free_tag_i   = TW'(k + 1);
      step();
    end
    idle();
    #1;
    chk("wrap_count", 32'(count_o), 31);
    chk("wrap_head", 32'(alloc_tag_o), 10);
    chk("wrap_ovf_sticky", 32'(overflow_o), 1);

    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
